// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle: raw buttons in, run/tick/clr/state out.
// master = button/datapath side, slave = the stopwatch_ctrl FSM.
interface stopwatch_ctrl_if;
    logic       start_n;
    logic       stop_n;
    logic       run;
    logic       tick;
    logic       clr;
    logic [1:0] state;

    modport master (
        output start_n, stop_n,
        input  run, tick, clr, state
    );

    modport slave (
        input  start_n, stop_n,
        output run, tick, clr, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button sync/edge, IDLE/RUN/PAUSE, tick and clr.
// Optional button debounce enabled by defining STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl #(
    parameter int CLK_DIV   = 500000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    stopwatch_ctrl_if.slave bus
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    // bit 0 = start, bit 1 = stop
    logic [1:0]    s1_q, s1_d;
    logic [1:0]    s2_q, s2_d;
    logic [1:0]    prv_q, prv_d;
    logic [1:0]    lvl;
    logic [1:0]    ev;
    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          clr_q, clr_d;
    logic          pre_end;

    // Two-flop synchronizer and edge history
    always_comb begin
        s1_d  = {bus.stop_n, bus.start_n};
        s2_d  = s1_q;
        prv_d = lvl;
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DW = $clog2(DB_CYCLES + 1);

    logic [1:0]         db_q, db_d;
    logic [1:0][DW-1:0] cnt_q, cnt_d;

    // Debounce: accept a new level only after DB_CYCLES stable cycles
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DW'(DB_CYCLES - 1)) begin
                    db_d[i]  = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q  <= 2'b11;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign lvl = db_q;
`else
    assign lvl = s2_q;
`endif

    // Press event: released last cycle, pressed now
    assign ev      = prv_q & ~lvl;
    assign pre_end = (pre_q == PW'(CLK_DIV - 1));

    // Next state, prescaler and clear pulse
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        clr_d   = 1'b0;
        if (ev[1]) begin
            state_d = IDLE;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE:    if (ev[0]) state_d = RUN;
                RUN:     if (ev[0]) state_d = PAUSE;
                PAUSE:   if (ev[0]) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
        if (state_d == IDLE) begin
            pre_d = '0;
        end else if (state_q == RUN) begin
            pre_d = pre_end ? '0 : pre_q + PW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 2'b11;
            s2_q    <= 2'b11;
            prv_q   <= 2'b11;
            state_q <= IDLE;
            pre_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prv_q   <= prv_d;
            state_q <= state_d;
            pre_q   <= pre_d;
            clr_q   <= clr_d;
        end
    end

    assign bus.run   = (state_q == RUN);
    assign bus.tick  = (state_q == RUN) && pre_end;
    assign bus.clr   = clr_q;
    assign bus.state = state_q;
endmodule
